// File: rtl/sap1_sequencer.sv
// SAP-1 microsequencer: six-state T ring plus opcode decode into the datapath control word.
// Optional single-step mode is compiled in when SAP1_STEP_EN is defined.
module sap1_sequencer #(
  parameter int             OPW    = 4,
  parameter logic [OPW-1:0] OP_LDA = 4'h0,
  parameter logic [OPW-1:0] OP_ADD = 4'h1,
  parameter logic [OPW-1:0] OP_SUB = 4'h2,
  parameter logic [OPW-1:0] OP_OUT = 4'hE,
  parameter logic [OPW-1:0] OP_HLT = 4'hF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           run_i,
  input  logic [OPW-1:0] opcode_i,
`ifdef SAP1_STEP_EN
  input  logic           step_mode_i,
  input  logic           step_i,
`endif
  output logic           pc_inc_o,
  output logic           pc_oe_o,
  output logic           mar_ld_o,
  output logic           mem_oe_o,
  output logic           ir_ld_o,
  output logic           ir_oe_o,
  output logic           a_ld_o,
  output logic           a_oe_o,
  output logic           b_ld_o,
  output logic           alu_oe_o,
  output logic           alu_sub_o,
  output logic           out_ld_o,
  output logic [5:0]     t_state_o,
  output logic           halted_o,
  output logic           instr_done_o
);

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_HALT = 3'd6
`ifdef SAP1_STEP_EN
    , S_WAIT = 3'd7
`endif
  } state_t;

  state_t state_q, state_d;
  logic   halted_q, halted_d;
  logic   active_s;

`ifdef SAP1_STEP_EN
  logic   step_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_T1;
      halted_q <= 1'b0;
`ifdef SAP1_STEP_EN
      step_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
`ifdef SAP1_STEP_EN
      step_q   <= step_i;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    unique case (state_q)
      S_T1:   state_d = run_i ? S_T2 : S_T1;
      S_T2:   state_d = run_i ? S_T3 : S_T2;
      S_T3:   state_d = run_i ? S_T4 : S_T3;
      S_T4: begin
        if (run_i && (opcode_i == OP_HLT)) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d  = run_i ? S_T5 : S_T4;
        end
      end
      S_T5:   state_d = run_i ? S_T6 : S_T5;
`ifdef SAP1_STEP_EN
      S_T6:   state_d = run_i ? (step_mode_i ? S_WAIT : S_T1) : S_T6;
      // Rising edge of STEP only, so a held STEP releases a single instruction.
      S_WAIT: state_d = (step_i && !step_q) ? S_T1 : S_WAIT;
`else
      S_T6:   state_d = run_i ? S_T1 : S_T6;
`endif
      S_HALT: state_d = S_HALT;
      default: state_d = S_T1;
    endcase
  end

  assign active_s = run_i & ~rst_i & ~halted_q;

  always_comb begin
    pc_inc_o     = 1'b0;
    pc_oe_o      = 1'b0;
    mar_ld_o     = 1'b0;
    mem_oe_o     = 1'b0;
    ir_ld_o      = 1'b0;
    ir_oe_o      = 1'b0;
    a_ld_o       = 1'b0;
    a_oe_o       = 1'b0;
    b_ld_o       = 1'b0;
    alu_oe_o     = 1'b0;
    alu_sub_o    = 1'b0;
    out_ld_o     = 1'b0;
    instr_done_o = 1'b0;
    if (active_s) begin
      unique case (state_q)
        S_T1: begin
          pc_oe_o  = 1'b1;
          mar_ld_o = 1'b1;
        end
        S_T2: pc_inc_o = 1'b1;
        S_T3: begin
          mem_oe_o = 1'b1;
          ir_ld_o  = 1'b1;
        end
        S_T4: begin
          if ((opcode_i == OP_LDA) || (opcode_i == OP_ADD) || (opcode_i == OP_SUB)) begin
            ir_oe_o  = 1'b1;
            mar_ld_o = 1'b1;
          end else if (opcode_i == OP_OUT) begin
            a_oe_o   = 1'b1;
            out_ld_o = 1'b1;
          end else begin
            ir_oe_o  = 1'b0;
          end
        end
        S_T5: begin
          if (opcode_i == OP_LDA) begin
            mem_oe_o = 1'b1;
            a_ld_o   = 1'b1;
          end else if ((opcode_i == OP_ADD) || (opcode_i == OP_SUB)) begin
            mem_oe_o = 1'b1;
            b_ld_o   = 1'b1;
          end else begin
            mem_oe_o = 1'b0;
          end
        end
        S_T6: begin
          instr_done_o = 1'b1;
          if ((opcode_i == OP_ADD) || (opcode_i == OP_SUB)) begin
            alu_oe_o  = 1'b1;
            a_ld_o    = 1'b1;
            alu_sub_o = (opcode_i == OP_SUB);
          end else begin
            alu_oe_o  = 1'b0;
          end
        end
        default: pc_inc_o = 1'b0;
      endcase
    end else begin
      instr_done_o = 1'b0;
    end
  end

  always_comb begin
    unique case (state_q)
      S_T1:    t_state_o = 6'b000001;
      S_T2:    t_state_o = 6'b000010;
      S_T3:    t_state_o = 6'b000100;
      S_T4:    t_state_o = 6'b001000;
      S_T5:    t_state_o = 6'b010000;
      S_T6:    t_state_o = 6'b100000;
      default: t_state_o = 6'b000000;
    endcase
  end

  assign halted_o = halted_q;

endmodule

// File: tb/tb_sap1_sequencer.sv
// Directed bench for sap1_sequencer (default build): expected control/T-state words are queued
// as each step is driven and popped for comparison on the following falling edge.
module tb_sap1_sequencer;

  localparam logic [11:0] C_NONE    = 12'h000;
  localparam logic [11:0] C_PC_INC  = 12'h800;
  localparam logic [11:0] C_PC_OE   = 12'h400;
  localparam logic [11:0] C_MAR_LD  = 12'h200;
  localparam logic [11:0] C_MEM_OE  = 12'h100;
  localparam logic [11:0] C_IR_LD   = 12'h080;
  localparam logic [11:0] C_IR_OE   = 12'h040;
  localparam logic [11:0] C_A_LD    = 12'h020;
  localparam logic [11:0] C_A_OE    = 12'h010;
  localparam logic [11:0] C_B_LD    = 12'h008;
  localparam logic [11:0] C_ALU_OE  = 12'h004;
  localparam logic [11:0] C_ALU_SUB = 12'h002;
  localparam logic [11:0] C_OUT_LD  = 12'h001;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;
  localparam logic [5:0] TZ = 6'b000000;

  logic       clk;
  logic       rst;
  logic       run;
  logic [3:0] opcode;
  logic       pc_inc, pc_oe, mar_ld, mem_oe, ir_ld, ir_oe;
  logic       a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld;
  logic [5:0] t_state;
  logic       halted, instr_done;

  int checks;
  int failures;

  // Packed as {t_state, halted, instr_done, control word}.
  logic [19:0] exp_q[$];

  sap1_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (run),
    .opcode_i     (opcode),
    .pc_inc_o     (pc_inc),
    .pc_oe_o      (pc_oe),
    .mar_ld_o     (mar_ld),
    .mem_oe_o     (mem_oe),
    .ir_ld_o      (ir_ld),
    .ir_oe_o      (ir_oe),
    .a_ld_o       (a_ld),
    .a_oe_o       (a_oe),
    .b_ld_o       (b_ld),
    .alu_oe_o     (alu_oe),
    .alu_sub_o    (alu_sub),
    .out_ld_o     (out_ld),
    .t_state_o    (t_state),
    .halted_o     (halted),
    .instr_done_o (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string tag, input logic r, input logic rn, input logic [3:0] op,
                      input logic [11:0] ctl, input logic [5:0] t, input logic h, input logic d);
    logic [19:0] obs;
    logic [19:0] exp;
    rst    = r;
    run    = rn;
    opcode = op;
    exp_q.push_back({t, h, d, ctl});
    @(negedge clk);
    obs = {t_state, halted, instr_done,
           pc_inc, pc_oe, mar_ld, mem_oe, ir_ld, ir_oe, a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld};
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h (t,halt,done,ctl)", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [3:0] op);
    step({tag, "_t1"}, 1'b0, 1'b1, op, C_PC_OE | C_MAR_LD, T1, 1'b0, 1'b0);
    step({tag, "_t2"}, 1'b0, 1'b1, op, C_PC_INC,           T2, 1'b0, 1'b0);
    step({tag, "_t3"}, 1'b0, 1'b1, op, C_MEM_OE | C_IR_LD, T3, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    run      = 1'b0;
    opcode   = 4'h0;
    @(posedge clk);
    #1;

    // Reset held: T1 with every control held low, even with RUN high.
    step("rst_a", 1'b1, 1'b0, 4'h0, C_NONE, T1, 1'b0, 1'b0);
    step("rst_b", 1'b1, 1'b1, 4'h0, C_NONE, T1, 1'b0, 1'b0);

    // LDA
    fetch("lda", 4'h0);
    step("lda_t4", 1'b0, 1'b1, 4'h0, C_IR_OE | C_MAR_LD,  T4, 1'b0, 1'b0);
    step("lda_t5", 1'b0, 1'b1, 4'h0, C_MEM_OE | C_A_LD,   T5, 1'b0, 1'b0);
    step("lda_t6", 1'b0, 1'b1, 4'h0, C_NONE,              T6, 1'b0, 1'b1);

    // ADD
    fetch("add", 4'h1);
    step("add_t4", 1'b0, 1'b1, 4'h1, C_IR_OE | C_MAR_LD,  T4, 1'b0, 1'b0);
    step("add_t5", 1'b0, 1'b1, 4'h1, C_MEM_OE | C_B_LD,   T5, 1'b0, 1'b0);
    step("add_t6", 1'b0, 1'b1, 4'h1, C_ALU_OE | C_A_LD,   T6, 1'b0, 1'b1);

    // SUB with RUN dropped for three cycles at T5
    fetch("sub", 4'h2);
    step("sub_t4", 1'b0, 1'b1, 4'h2, C_IR_OE | C_MAR_LD,  T4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("sub_t5_frz", 1'b0, 1'b0, 4'h2, C_NONE,        T5, 1'b0, 1'b0);
    step("sub_t5", 1'b0, 1'b1, 4'h2, C_MEM_OE | C_B_LD,   T5, 1'b0, 1'b0);
    step("sub_t6", 1'b0, 1'b1, 4'h2, C_ALU_OE | C_ALU_SUB | C_A_LD, T6, 1'b0, 1'b1);

    // OUT, with a RUN drop at T6 that must suppress INSTR_DONE
    fetch("out", 4'hE);
    step("out_t4", 1'b0, 1'b1, 4'hE, C_A_OE | C_OUT_LD,   T4, 1'b0, 1'b0);
    step("out_t5", 1'b0, 1'b1, 4'hE, C_NONE,              T5, 1'b0, 1'b0);
    step("out_t6_frz", 1'b0, 1'b0, 4'hE, C_NONE,          T6, 1'b0, 1'b0);
    step("out_t6", 1'b0, 1'b1, 4'hE, C_NONE,              T6, 1'b0, 1'b1);

    // Unknown opcode behaves as NOP, still six cycles
    fetch("nop", 4'h7);
    step("nop_t4", 1'b0, 1'b1, 4'h7, C_NONE,              T4, 1'b0, 1'b0);
    step("nop_t5", 1'b0, 1'b1, 4'h7, C_NONE,              T5, 1'b0, 1'b0);
    step("nop_t6", 1'b0, 1'b1, 4'h7, C_NONE,              T6, 1'b0, 1'b1);

    // Reset mid-fetch (reset wins over RUN), then restart at T1
    step("mid_t1", 1'b0, 1'b1, 4'h1, C_PC_OE | C_MAR_LD,  T1, 1'b0, 1'b0);
    step("mid_rst", 1'b1, 1'b1, 4'h1, C_NONE,             T2, 1'b0, 1'b0);

    // HLT
    fetch("hlt", 4'hF);
    step("hlt_t4", 1'b0, 1'b1, 4'hF, C_NONE,              T4, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step("hlt_hold", 1'b0, logic'(i % 2), 4'h0, C_NONE, TZ, 1'b1, 1'b0);
    step("hlt_rst", 1'b1, 1'b1, 4'h0, C_NONE,             TZ, 1'b1, 1'b0);
    step("hlt_exit", 1'b0, 1'b1, 4'h0, C_PC_OE | C_MAR_LD, T1, 1'b0, 1'b0);
    step("hlt_exit_t2", 1'b0, 1'b1, 4'h0, C_PC_INC,       T2, 1'b0, 1'b0);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
